i2s_tx_serializer: RTL and testbench
====================================

Name: i2s_tx_serializer

Overview:
- Output stage directly downstream of the DSP chain. Consumes mono signed 24-bit samples on a valid/ready stream and drives a Philips I2S transmitter interface (bclk, lrclk, sdata) to the DAC.
- Each sample is sent identically on the left and right slots.
- A small input FIFO absorbs DSP output jitter. Frame timing comes from a bit-clock divider on the system clock.

Parameters:
- G_DWIDTH, 24, sample width in bits (must be <= G_SLOT_WIDTH-1).
- G_SLOT_WIDTH, 32, bclk periods per channel slot; frame = 2*G_SLOT_WIDTH bclk.
- G_BCLK_DIV, 4, clk cycles per bclk period; even, >= 2.
- G_FIFO_DEPTH_LOG2, 2, log2 of input FIFO depth (default 4 entries).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  block enable; 0 = synchronous clear, equivalent to reset
- din  in  G_DWIDTH  signed sample, two's complement
- din_valid  in  1  sample valid
- din_ready  out  1  FIFO not full
- i2s_bclk  out  1  bit clock, registered
- i2s_lrclk  out  1  word select; 0 = left, 1 = right; registered
- i2s_sdata  out  1  serial data, MSB first; registered
- frame_start  out  1  one-clk pulse when a new frame is loaded
- underflow  out  1  one-clk pulse when a frame loads with the FIFO empty
- underflow_count  out  16  saturating count of underflow events

Behaviour:
- Reset (async) and enable=0 (sync) have the same effect:
  - bclk, lrclk, sdata, frame_start, underflow = 0; underflow_count = 0; din_ready = 0.
  - FIFO flushed; divider and bit counters = 0; shift register = 0.
- Reset asserted mid-frame aborts the frame immediately. After release, transmission restarts at bit 0 of a left slot.
- FIFO:
  - Push on din_valid & din_ready.
  - din_ready = !full, registered. No same-cycle pass-through when full, even if a pop occurs that cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged.
- Divider:
  - div_cnt counts 0..G_BCLK_DIV-1 and wraps.
  - bclk rises when div_cnt reaches G_BCLK_DIV/2-1 (rise event) and falls when div_cnt wraps to 0 (fall event).
  - All data and lrclk changes happen on fall events only.
- Bit counter:
  - bit_cnt counts 0..2*G_SLOT_WIDTH-1 and advances on each fall event.
  - lrclk = (bit_cnt >= G_SLOT_WIDTH), registered together with bit_cnt.
- Slot position p = bit_cnt mod G_SLOT_WIDTH (I2S one-bclk delay):
  - p = 0: sdata = 0.
  - p = 1..G_DWIDTH: sdata = sample bit [G_DWIDTH-p], so the MSB is sent at p = 1.
  - p > G_DWIDTH: sdata = 0.
- Frame load, on the fall event where bit_cnt wraps to 0:
  - If the FIFO is not empty: pop into the frame register and pulse frame_start.
  - If the FIFO is empty: load 0, pulse frame_start and underflow, and increment underflow_count (saturates at 0xFFFF).
  - The frame register is held for both slots of the frame.
- First frame after reset: the first fall event occurs G_BCLK_DIV clk cycles after release and loads frame 0 using the rule above.
- Latency: from a push into an empty FIFO until its MSB appears on sdata is at most one frame (2*G_SLOT_WIDTH*G_BCLK_DIV clk), plus one bclk period.
- Throughput: one sample per frame. Upstream back-pressure comes through din_ready only.

Test Plan:
- Defaults, push 0x800001 then idle:
  - frame_start pulses; left slot sdata over p=0..25 = 0,1,0x22,1,0.
  - Right slot repeats the same pattern with lrclk=1.
  - Next frame: zero data, underflow pulses, underflow_count=1.
- Hold din_valid=1 with 5 distinct samples from reset:
  - Exactly 4 accepted before din_ready drops.
  - One more accepted after each frame_start.
  - Output order matches input order.
- Check bclk and frame timing:
  - bclk period = 4 clk with 50% duty.
  - lrclk toggles every 128 clk; frame_start period = 256 clk.
  - sdata and lrclk change only coincident with bclk falling.
- Assert reset for 3 clk in the middle of the right slot:
  - All outputs are 0 within the reset cycle, without waiting for a clk edge.
  - FIFO empty; underflow_count=0.
  - After release, the first frame starts at the left slot with bit_cnt=0.
- Drop enable=0 for 10 clk mid-frame with 2 samples queued:
  - Same as reset: outputs cleared and the queued samples discarded.
  - On re-enable, the first frame underflows (count=1).
- Leave the FIFO empty for 70000 frames (force or speed up with G_BCLK_DIV=2, G_SLOT_WIDTH=25):
  - underflow_count saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
// Philips I2S transmitter for a mono sample stream. Each accepted sample is
// buffered in a small FIFO, loaded once per frame and sent MSB first on both
// the left and the right slot, one bclk after the lrclk transition.
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   enable          block enable; low acts as a synchronous clear
//   din             signed sample, two's complement
//   din_valid       sample valid
//   din_ready       FIFO not full (registered)
//   i2s_bclk        bit clock (registered)
//   i2s_lrclk       word select, 0 = left, 1 = right (registered)
//   i2s_sdata       serial data, MSB first (registered)
//   frame_start     one-clk pulse when a frame is loaded
//   underflow       one-clk pulse when a frame loads from an empty FIFO
//   underflow_count saturating count of underflow events
module i2s_tx_serializer #(
  parameter int G_DWIDTH          = 24,
  parameter int G_SLOT_WIDTH      = 32,
  parameter int G_BCLK_DIV        = 4,
  parameter int G_FIFO_DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [G_DWIDTH-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                frame_start,
  output logic                underflow,
  output logic [15:0]         underflow_count
);

  localparam int FRAME_BITS = 2 * G_SLOT_WIDTH;
  localparam int DEPTH      = 1 << G_FIFO_DEPTH_LOG2;
  localparam int BCW        = $clog2(FRAME_BITS);
  localparam int DCW        = (G_BCLK_DIV > 2) ? $clog2(G_BCLK_DIV) : 1;
  localparam int PW         = G_FIFO_DEPTH_LOG2;
  localparam int CW         = G_FIFO_DEPTH_LOG2 + 1;

  logic [DCW-1:0]      div_cnt_r;
  logic [BCW-1:0]      bit_cnt_r;
  logic                started_r;
  logic [G_DWIDTH-1:0] frame_r;
  logic                bclk_r;
  logic                lrclk_r;
  logic                sdata_r;
  logic                frame_start_r;
  logic                underflow_r;
  logic [15:0]         underflow_count_r;
  logic [G_DWIDTH-1:0] fifo_mem_r [DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic                din_ready_r;

  logic                rise_ev_s;
  logic                fall_ev_s;
  logic                frame_wrap_s;
  logic                fifo_empty_s;
  logic                push_s;
  logic                pop_s;
  logic [CW-1:0]       count_nxt_s;
  logic [BCW-1:0]      bit_cnt_nxt_s;
  logic [G_DWIDTH-1:0] frame_nxt_s;
  logic [BCW-1:0]      slot_pos_s;
  logic [BCW-1:0]      sel_s;
  logic [G_DWIDTH-1:0] shifted_s;
  logic                sdata_nxt_s;

  // Divider events, FIFO bookkeeping, frame load and next serial bit.
  always_comb begin
    rise_ev_s     = (div_cnt_r == DCW'(G_BCLK_DIV / 2 - 1));
    fall_ev_s     = (div_cnt_r == DCW'(G_BCLK_DIV - 1));
    // The very first fall event after reset loads frame 0 without waiting
    // for bit_cnt to run through a whole frame.
    frame_wrap_s  = fall_ev_s && (!started_r || (bit_cnt_r == BCW'(FRAME_BITS - 1)));
    fifo_empty_s  = (count_r == CW'(0));
    push_s        = din_valid && din_ready_r;
    pop_s         = frame_wrap_s && !fifo_empty_s;

    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase

    bit_cnt_nxt_s = bit_cnt_r;
    frame_nxt_s   = frame_r;
    if (frame_wrap_s) begin
      bit_cnt_nxt_s = BCW'(0);
      if (pop_s) begin
        frame_nxt_s = fifo_mem_r[rd_ptr_r];
      end else begin
        frame_nxt_s = '0;
      end
    end else if (fall_ev_s) begin
      bit_cnt_nxt_s = bit_cnt_r + BCW'(1);
    end else begin
      bit_cnt_nxt_s = bit_cnt_r;
    end

    if (bit_cnt_nxt_s >= BCW'(G_SLOT_WIDTH)) begin
      slot_pos_s = bit_cnt_nxt_s - BCW'(G_SLOT_WIDTH);
    end else begin
      slot_pos_s = bit_cnt_nxt_s;
    end

    // Position p carries sample bit [G_DWIDTH-p]; p = 0 is the I2S delay bit.
    sel_s     = BCW'(G_DWIDTH) - slot_pos_s;
    shifted_s = frame_nxt_s >> sel_s;
    if ((slot_pos_s >= BCW'(1)) && (slot_pos_s <= BCW'(G_DWIDTH))) begin
      sdata_nxt_s = shifted_s[0];
    end else begin
      sdata_nxt_s = 1'b0;
    end
  end

  // Control, divider, frame and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r         <= '0;
      bit_cnt_r         <= '0;
      started_r         <= 1'b0;
      frame_r           <= '0;
      bclk_r            <= 1'b0;
      lrclk_r           <= 1'b0;
      sdata_r           <= 1'b0;
      frame_start_r     <= 1'b0;
      underflow_r       <= 1'b0;
      underflow_count_r <= 16'h0000;
      wr_ptr_r          <= '0;
      rd_ptr_r          <= '0;
      count_r           <= '0;
      din_ready_r       <= 1'b0;
    end else if (!enable) begin
      div_cnt_r         <= '0;
      bit_cnt_r         <= '0;
      started_r         <= 1'b0;
      frame_r           <= '0;
      bclk_r            <= 1'b0;
      lrclk_r           <= 1'b0;
      sdata_r           <= 1'b0;
      frame_start_r     <= 1'b0;
      underflow_r       <= 1'b0;
      underflow_count_r <= 16'h0000;
      wr_ptr_r          <= '0;
      rd_ptr_r          <= '0;
      count_r           <= '0;
      din_ready_r       <= 1'b0;
    end else begin
      if (fall_ev_s) begin
        div_cnt_r <= '0;
      end else begin
        div_cnt_r <= div_cnt_r + DCW'(1);
      end
      if (rise_ev_s) begin
        bclk_r <= 1'b1;
      end else if (fall_ev_s) begin
        bclk_r <= 1'b0;
      end else begin
        bclk_r <= bclk_r;
      end
      started_r     <= started_r | fall_ev_s;
      bit_cnt_r     <= bit_cnt_nxt_s;
      frame_r       <= frame_nxt_s;
      lrclk_r       <= (bit_cnt_nxt_s >= BCW'(G_SLOT_WIDTH));
      sdata_r       <= sdata_nxt_s;
      frame_start_r <= frame_wrap_s;
      underflow_r   <= frame_wrap_s && fifo_empty_s;
      if (frame_wrap_s && fifo_empty_s && (underflow_count_r != 16'hFFFF)) begin
        underflow_count_r <= underflow_count_r + 16'h0001;
      end else begin
        underflow_count_r <= underflow_count_r;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r     <= count_nxt_s;
      din_ready_r <= (count_nxt_s != CW'(DEPTH));
    end
  end

  // FIFO storage; contents are don't-care while the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= din;
    end
  end

  assign din_ready       = din_ready_r;
  assign i2s_bclk        = bclk_r;
  assign i2s_lrclk       = lrclk_r;
  assign i2s_sdata       = sdata_r;
  assign frame_start     = frame_start_r;
  assign underflow       = underflow_r;
  assign underflow_count = underflow_count_r;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed self-checking bench for i2s_tx_serializer with default parameters.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [23:0] din = 24'h000000;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        frame_start;
  logic        underflow;
  logic [15:0] underflow_count;

  int n_checks = 0;
  int n_fail   = 0;

  i2s_tx_serializer dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .din             (din),
    .din_valid       (din_valid),
    .din_ready       (din_ready),
    .i2s_bclk        (i2s_bclk),
    .i2s_lrclk       (i2s_lrclk),
    .i2s_sdata       (i2s_sdata),
    .frame_start     (frame_start),
    .underflow       (underflow),
    .underflow_count (underflow_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_bclk"},  {31'd0, i2s_bclk},  32'd0);
    check({tag, "_lrclk"}, {31'd0, i2s_lrclk}, 32'd0);
    check({tag, "_sdata"}, {31'd0, i2s_sdata}, 32'd0);
    check({tag, "_fs"},    {31'd0, frame_start}, 32'd0);
    check({tag, "_uf"},    {31'd0, underflow}, 32'd0);
    check({tag, "_ucnt"},  {16'd0, underflow_count}, 32'd0);
    check({tag, "_ready"}, {31'd0, din_ready}, 32'd0);
  endtask

  task automatic wait_fs(input int bound);
    int k;
    k = 0;
    while (!frame_start && k < bound) begin
      tick(1);
      k++;
    end
    check("fs_seen", {31'd0, frame_start}, 32'd1);
  endtask

  task automatic push(input logic [23:0] d);
    logic acc;
    int   k;
    din       = d;
    din_valid = 1'b1;
    acc       = 1'b0;
    k         = 0;
    while (!acc && k < 600) begin
      acc = din_ready;
      tick(1);
      k++;
    end
    din_valid = 1'b0;
    check("push_accept", {31'd0, acc}, 32'd1);
  endtask

  // Collects left (p=1..24) and right (p=33..56) sample bits; off is the
  // clk offset from the frame_start sample point at entry.
  task automatic read_frame(input int off, output logic [23:0] l, output logic [23:0] r);
    l = 24'h000000;
    r = 24'h000000;
    tick(4 - off);
    for (int p = 1; p <= 56; p++) begin
      if (p <= 24) l[24 - p] = i2s_sdata;
      if (p >= 33) r[56 - p] = i2s_sdata;
      if (p < 56) tick(4);
    end
  endtask

  function automatic logic exp_bit(input logic [23:0] s, input int p);
    int q;
    q = p % 32;
    if (q >= 1 && q <= 24) return s[24 - q];
    else return 1'b0;
  endfunction

  logic [23:0] smp [5];
  logic [23:0] l_s;
  logic [23:0] r_s;
  logic        acc;
  int          idx;
  int          k;

  initial begin
    smp[0] = 24'h123456; smp[1] = 24'hABCDEF; smp[2] = 24'h800000;
    smp[3] = 24'h7FFFFF; smp[4] = 24'h0F0F0F;

    // Reset state and the first frame carrying 0x800001.
    tick(2);
    check_cleared("rst0");
    reset = 1'b0;
    push(24'h800001);
    wait_fs(20);
    for (int c = 0; c < 256; c++) begin
      check("t1_sdata", {31'd0, i2s_sdata}, {31'd0, exp_bit(24'h800001, c / 4)});
      check("t1_lrclk", {31'd0, i2s_lrclk}, (c >= 128) ? 32'd1 : 32'd0);
      check("t1_bclk",  {31'd0, i2s_bclk},  ((c % 4) >= 2) ? 32'd1 : 32'd0);
      check("t1_fs",    {31'd0, frame_start}, (c == 0) ? 32'd1 : 32'd0);
      check("t1_uf",    {31'd0, underflow}, 32'd0);
      tick(1);
    end
    check("t1_fs_next",  {31'd0, frame_start}, 32'd1);
    check("t1_uf_next",  {31'd0, underflow}, 32'd1);
    check("t1_ucnt",     {16'd0, underflow_count}, 32'd1);
    check("t1_sd_next",  {31'd0, i2s_sdata}, 32'd0);

    // Back-pressure and ordering with din_valid held high.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    wait_fs(20);
    idx       = 0;
    din       = smp[0];
    din_valid = 1'b1;
    k         = 0;
    while (din_ready && k < 20) begin
      acc = din_ready;
      tick(1);
      if (acc) begin
        idx++;
        if (idx < 5) din = smp[idx];
      end
      k++;
    end
    check("t2_accept_full", idx, 32'd4);
    check("t2_ready_low", {31'd0, din_ready}, 32'd0);
    k = 0;
    while (!frame_start && k < 300) begin
      acc = din_ready;
      tick(1);
      if (acc) idx++;
      k++;
    end
    check("t2_fs", {31'd0, frame_start}, 32'd1);
    check("t2_no_accept_full", idx, 32'd4);
    check("t2_ready_after_fs", {31'd0, din_ready}, 32'd1);
    acc = din_ready;
    tick(1);
    if (acc) idx++;
    din_valid = 1'b0;
    check("t2_accept_fifth", idx, 32'd5);
    check("t2_ready_low2", {31'd0, din_ready}, 32'd0);
    read_frame(1, l_s, r_s);
    check("t2_left0", {8'd0, l_s}, {8'd0, smp[0]});
    check("t2_right0", {8'd0, r_s}, {8'd0, smp[0]});
    for (int i = 1; i < 5; i++) begin
      wait_fs(300);
      check("t2_no_uf", {31'd0, underflow}, 32'd0);
      read_frame(0, l_s, r_s);
      check("t2_left", {8'd0, l_s}, {8'd0, smp[i]});
      check("t2_right", {8'd0, r_s}, {8'd0, smp[i]});
    end
    wait_fs(300);
    check("t2_uf_end", {31'd0, underflow}, 32'd1);
    check("t2_ucnt", {16'd0, underflow_count}, 32'd2);

    // Asynchronous reset in the middle of the right slot.
    push(24'hFFFFFF);
    push(24'h123456);
    tick(1);
    wait_fs(300);
    check("t3_loaded", {31'd0, underflow}, 32'd0);
    tick(4 * 40 + 2);
    check("t3_pre_bclk",  {31'd0, i2s_bclk},  32'd1);
    check("t3_pre_lrclk", {31'd0, i2s_lrclk}, 32'd1);
    check("t3_pre_sdata", {31'd0, i2s_sdata}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_cleared("t3_async");
    tick(3);
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick(1);
      check("t3_first_fs", {31'd0, frame_start}, (c == 4) ? 32'd1 : 32'd0);
    end
    check("t3_uf",    {31'd0, underflow}, 32'd1);
    check("t3_ucnt",  {16'd0, underflow_count}, 32'd1);
    check("t3_lr0",   {31'd0, i2s_lrclk}, 32'd0);
    tick(4 * 31);
    check("t3_lr31",  {31'd0, i2s_lrclk}, 32'd0);
    tick(4);
    check("t3_lr32",  {31'd0, i2s_lrclk}, 32'd1);

    // Enable dropped for 10 clk with two samples queued.
    push(24'hFFFFFF);
    tick(1);
    wait_fs(300);
    push(24'hAAAAAA);
    push(24'h555555);
    tick(4 * 10);
    check("t4_pre_bclk",  {31'd0, i2s_bclk},  32'd1);
    check("t4_pre_sdata", {31'd0, i2s_sdata}, 32'd1);
    check("t4_pre_ucnt",  {16'd0, underflow_count}, 32'd1);
    enable = 1'b0;
    tick(1);
    check_cleared("t4_clear");
    tick(9);
    enable = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick(1);
      check("t4_first_fs", {31'd0, frame_start}, (c == 4) ? 32'd1 : 32'd0);
    end
    check("t4_uf",   {31'd0, underflow}, 32'd1);
    check("t4_ucnt", {16'd0, underflow_count}, 32'd1);
    tick(1);
    wait_fs(300);
    check("t4_uf2",   {31'd0, underflow}, 32'd1);
    check("t4_ucnt2", {16'd0, underflow_count}, 32'd2);

    // Saturation of underflow_count, preloaded near the top.
    force dut.underflow_count_r = 16'hFFFD;
    #1;
    release dut.underflow_count_r;
    check("t5_preload", {16'd0, underflow_count}, 32'h0000FFFD);
    tick(1);
    wait_fs(300);
    check("t5_uf_a",   {31'd0, underflow}, 32'd1);
    check("t5_ucnt_a", {16'd0, underflow_count}, 32'h0000FFFE);
    tick(1);
    wait_fs(300);
    check("t5_ucnt_b", {16'd0, underflow_count}, 32'h0000FFFF);
    tick(1);
    wait_fs(300);
    check("t5_uf_c",   {31'd0, underflow}, 32'd1);
    check("t5_ucnt_c", {16'd0, underflow_count}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
